// File: rtl/mips_pkg.sv
// Shared multiply/divide definitions: operation encodings, FSM states and
// fixed constants used by the HI/LO unit.
package mips_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = MD_WIDTH;
  localparam logic [MD_WIDTH-1:0] DIV0_QUOT = '1;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_MADD  = 3'b010,
    MD_MADDU = 3'b011,
    MD_DIV   = 3'b100,
    MD_DIVU  = 3'b101,
    MD_MTHI  = 3'b110,
    MD_MTLO  = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } md_state_t;

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MADD) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide unit.
interface muldiv_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  logic             start;
  md_op_t           md_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, a, b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, md_op, a, b, flush,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate; with neg_i tied to the sign bit it
// doubles as an absolute-value stage.
module md_sign_fix #(
  parameter int W = 64
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
//   state  | meaning
//   IDLE   | waiting for start; mthi/mtlo complete here in one cycle
//   CALC   | one shift-add multiply or restoring divide step per cycle
//   FINISH | sign fix and HI/LO write, done pulse follows
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_unit_if.slave  md
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  md_op_t             op_q, op_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               sign_a, sign_b, op_is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix, madd_sum;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;

  assign sign_a    = md_is_signed(md.md_op) & md.a[WIDTH-1];
  assign sign_b    = md_is_signed(md.md_op) & md.b[WIDTH-1];
  assign op_is_div = (md.md_op == MD_DIV) || (md.md_op == MD_DIVU);

  md_sign_fix #(.W(WIDTH)) u_abs_a (.val_i(md.a), .neg_i(sign_a), .res_o(a_mag));
  md_sign_fix #(.W(WIDTH)) u_abs_b (.val_i(md.b), .neg_i(sign_b), .res_o(b_mag));
  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (.val_i(acc_q), .neg_i(neg_q), .res_o(prod_fix));
  md_sign_fix #(.W(WIDTH)) u_fix_quot (.val_i(sreg_q), .neg_i(neg_q), .res_o(quot_fix));
  md_sign_fix #(.W(WIDTH)) u_fix_rem
    (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .res_o(rem_fix));

  // Multiply: add into the upper half, then shift the whole accumulator right.
  // Divide: partial remainder lives in the upper half, quotient shifts into sreg.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (sreg_q[0] ? {1'b0, mcand_q} : '0);
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], sreg_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, mcand_q};
  assign madd_sum = {hi_q, lo_q} + prod_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= MD_MULT;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      mcand_q   <= '0;
      sreg_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      mcand_q   <= mcand_d;
      sreg_q    <= sreg_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    mcand_d   = mcand_q;
    sreg_d    = sreg_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!md.flush && md.start) begin
          if (md.md_op == MD_MTHI) begin
            hi_d   = md.a;
            done_d = 1'b1;
          end else if (md.md_op == MD_MTLO) begin
            lo_d   = md.a;
            done_d = 1'b1;
          end else begin
            op_d      = md.md_op;
            mcand_d   = op_is_div ? b_mag : a_mag;
            sreg_d    = op_is_div ? a_mag : b_mag;
            neg_d     = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            acc_d     = '0;
            cnt_d     = '0;
            div0_d    = op_is_div && (md.b == '0);
            if (op_is_div && (md.b == '0)) begin
              // Raw dividend is what ends up in HI on a divide by zero.
              sreg_d  = md.a;
              state_d = FINISH;
            end else begin
              state_d = CALC;
            end
          end
        end
      end

      CALC: begin
        if (md.flush) begin
          state_d = IDLE;
        end else begin
          if (op_q[2]) begin
            acc_d  = {rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0],
                      acc_q[WIDTH-1:0]};
            sreg_d = {sreg_q[WIDTH-2:0], ~rem_diff[WIDTH]};
          end else begin
            acc_d  = {mul_sum, acc_q[WIDTH-1:1]};
            sreg_d = sreg_q >> 1;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
        end
      end

      FINISH: begin
        state_d = IDLE;
        if (!md.flush) begin
          done_d = 1'b1;
          if (div0_q) begin
            hi_d  = sreg_q;
            lo_d  = {WIDTH{1'b1}};
            dbz_d = 1'b1;
          end else if (op_q[2]) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else if (op_q[1]) begin
            {hi_d, lo_d} = madd_sum;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign md.busy        = (state_q != IDLE);
  assign md.done        = done_q;
  assign md.div_by_zero = dbz_q;
  assign md.hi          = hi_q;
  assign md.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic HI/LO model.
module tb_muldiv_unit;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   errors;

  logic [31:0] hi_m, lo_m;
  logic        dbz_m;

  muldiv_unit_if #(.WIDTH(32)) md ();
  muldiv_unit #(.WIDTH(32)) u_dut (.clk(clk), .rst_n(rst_n), .md(md));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    p = '0;
    dbz_m = 1'b0;
    case (op)
      MD_MTHI: hi_m = a;
      MD_MTLO: lo_m = a;
      MD_MULT, MD_MADD: begin
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        p  = 64'(sa * sb);
      end
      MD_MULTU, MD_MADDU: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) begin
          lo_m = 32'hFFFF_FFFF;
          hi_m = a;
          dbz_m = 1'b1;
        end else begin
          if (op == MD_DIV) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
          end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
          end
          q = sa / sb;
          r = sa % sb;
          lo_m = q[31:0];
          hi_m = r[31:0];
        end
      end
    endcase
    if (op == MD_MULT || op == MD_MULTU) {hi_m, lo_m} = p;
    if (op == MD_MADD || op == MD_MADDU) {hi_m, lo_m} = {hi_m, lo_m} + p;
  endfunction

  function automatic int exp_latency(input md_op_t op, input logic [31:0] b);
    if (op == MD_MTHI || op == MD_MTLO) return 0;
    if ((op == MD_DIV || op == MD_DIVU) && b == 32'd0) return 1;
    return 33;
  endfunction

  // Launch one op, wait for done and compare timing and results with the model.
  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    int n, busy_cnt, lat;
    lat = exp_latency(op, b);
    model_op(op, a, b);
    md.start = 1'b1; md.md_op = op; md.a = a; md.b = b;
    @(posedge clk); #1;
    md.start = 1'b0; md.a = $urandom; md.b = $urandom;
    md.md_op = md_op_t'($urandom_range(0, 7));
    n = 0; busy_cnt = 0;
    while (!md.done && n < 60) begin
      if (md.busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, n, lat);
    end
    tests++;
    if (busy_cnt !== lat) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, lat);
    end
    tests++;
    if (md.hi !== hi_m || md.lo !== lo_m) begin
      errors++;
      $display("FAIL %s hi/lo: got %h_%h expected %h_%h", name, md.hi, md.lo, hi_m, lo_m);
    end
    tests++;
    if (md.div_by_zero !== dbz_m) begin
      errors++;
      $display("FAIL %s div_by_zero: got %b expected %b", name, md.div_by_zero, dbz_m);
    end
    @(posedge clk); #1;
    tests++;
    if (md.done !== 1'b0 || md.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse width: done %b dbz %b expected 0 0", name, md.done, md.div_by_zero);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    md.start = 1'b0; md.flush = 1'b0; md.md_op = MD_MULT; md.a = '0; md.b = '0;
    hi_m = '0; lo_m = '0; dbz_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (md.busy !== 1'b0 || md.done !== 1'b0 || md.div_by_zero !== 1'b0 ||
        md.hi !== 32'd0 || md.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset state: busy %b done %b dbz %b hi %h lo %h expected all 0",
               md.busy, md.done, md.div_by_zero, md.hi, md.lo);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
    tests++;
    if (md.hi !== 32'hFFFF_FFFF || md.lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_neg3x7 const: got %h_%h expected ffffffff_ffffffeb", md.hi, md.lo);
    end
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(MD_MTLO, 32'hFFFF_FFFF, 32'd0, "mtlo");
    run_op(MD_MTHI, 32'd0, 32'd0, "mthi");
    run_op(MD_MADDU, 32'd1, 32'd1, "maddu_carry");
    tests++;
    if (md.hi !== 32'd1 || md.lo !== 32'd0) begin
      errors++;
      $display("FAIL maddu_carry const: got %h_%h expected 00000001_00000000", md.hi, md.lo);
    end
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    tests++;
    if (md.hi !== 32'd0 || md.lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_overflow const: got %h_%h expected 00000000_80000000", md.hi, md.lo);
    end
    run_op(MD_DIVU, 32'd7, 32'd0, "divu_by_zero");
    run_op(MD_DIV, 32'd100, 32'hFFFF_FFF9, "div_pos_by_neg");
    run_op(MD_MADD, 32'hFFFF_FFFF, 32'd5, "madd_neg");
  endtask

  task automatic test_random();
    md_op_t      op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = md_op_t'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      run_op(op, a, b, "random");
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    model_op(MD_MULT, a, b);
    md.start = 1'b1; md.md_op = MD_MULT; md.a = a; md.b = b;
    @(posedge clk); #1;
    md.start = 1'b0;
    n = 0;
    while (!md.done && n < 60) begin
      md.start = (n == 5);
      md.md_op = MD_DIVU; md.a = 32'd9; md.b = 32'd0;
      @(posedge clk); #1;
      n++;
    end
    md.start = 1'b0;
    tests++;
    if (n !== 33 || md.hi !== hi_m || md.lo !== lo_m) begin
      errors++;
      $display("FAIL start_while_busy: lat %0d hi/lo %h_%h expected 33 %h_%h",
               n, md.hi, md.lo, hi_m, lo_m);
    end
    @(posedge clk); #1;
    tests++;
    if (md.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_while_busy queued: busy %b expected 0", md.busy);
    end
  endtask

  task automatic test_flush();
    int seen_done;
    md.start = 1'b1; md.md_op = MD_MULT; md.a = $urandom; md.b = $urandom;
    @(posedge clk); #1;
    md.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    md.flush = 1'b1;
    @(posedge clk); #1;
    md.flush = 1'b0;
    tests++;
    if (md.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush busy: got %b expected 0", md.busy);
    end
    seen_done = 0;
    repeat (40) begin
      if (md.done) seen_done++;
      @(posedge clk); #1;
    end
    tests++;
    if (seen_done !== 0 || md.hi !== hi_m || md.lo !== lo_m) begin
      errors++;
      $display("FAIL flush hold: dones %0d hi/lo %h_%h expected 0 %h_%h",
               seen_done, md.hi, md.lo, hi_m, lo_m);
    end
    md.start = 1'b1; md.flush = 1'b1; md.md_op = MD_MTHI; md.a = ~hi_m;
    @(posedge clk); #1;
    md.start = 1'b0; md.flush = 1'b0;
    tests++;
    if (md.done !== 1'b0 || md.hi !== hi_m) begin
      errors++;
      $display("FAIL flush over mthi: done %b hi %h expected 0 %h", md.done, md.hi, hi_m);
    end
  endtask

  task automatic test_async_reset();
    md.start = 1'b1; md.md_op = MD_MULTU; md.a = $urandom; md.b = $urandom;
    @(posedge clk); #1;
    md.start = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (md.busy !== 1'b0 || md.done !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0) begin
      errors++;
      $display("FAIL async reset: busy %b done %b hi %h lo %h expected 0 0 0 0",
               md.busy, md.done, md.hi, md.lo);
    end
    hi_m = '0; lo_m = '0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(MD_MULT, $urandom, $urandom, "after_reset");
  endtask

  initial begin
    tests = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
